// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// default latencies and op-class helpers used by decode and stall logic.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6
    } md_op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } md_state_e;

    localparam int unsigned DefaultMultCycles = 5;
    localparam int unsigned DefaultDivCycles  = 10;

    // Ops that occupy the unit for a multi-cycle busy period
    function automatic logic is_muldiv(md_op_e op);
        return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
    endfunction

    function automatic logic is_mul(md_op_e op);
        return (op == OpMult) || (op == OpMultu);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// MIPS-style HI/LO multiply/divide unit. A mul/div start latches the
// operands and holds busy for a fixed number of cycles; the result is
// committed to HI/LO on the last busy edge. MTHI/MTLO write immediately.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefaultMultCycles,
    parameter int unsigned DIV_CYCLES  = DefaultDivCycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_hi,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall_req
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    md_op_e      op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    md_op_e      op_in;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_ovf;
    logic [31:0] div_b_s;
    logic [31:0] div_b_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    assign op_in = md_op_e'(op);

    // Datapath on latched operands. Zero divisors and the signed overflow case
    // divide by 1 instead: for 0x80000000 / -1 that yields exactly the wrapped
    // quotient and zero remainder, and divide-by-zero results are discarded.
    assign prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u  = {32'd0, a_q} * {32'd0, b_q};
    assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign div_b_s = ((b_q == 32'd0) || div_ovf) ? 32'd1 : b_q;
    assign div_b_u = (b_q == 32'd0) ? 32'd1 : b_q;
    assign quot_s  = $signed(a_q) / $signed(div_b_s);
    assign rem_s   = $signed(a_q) % $signed(div_b_s);
    assign quot_u  = a_q / div_b_u;
    assign rem_u   = a_q % div_b_u;

    // Next-state: accept ops in IDLE, count down in BUSY, commit at expiry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_muldiv(op_in)) begin
                        state_d = StBusy;
                        op_d    = op_in;
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = is_mul(op_in) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                    end else if (op_in == OpMthi) begin
                        hi_d = a;
                    end else if (op_in == OpMtlo) begin
                        lo_d = a;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    case (op_q)
                        OpMult:  {hi_d, lo_d} = prod_s;
                        OpMultu: {hi_d, lo_d} = prod_u;
                        OpDiv: begin
                            if (b_q != 32'd0) begin
                                lo_d = quot_s;
                                hi_d = rem_s;
                            end
                        end
                        OpDivu: begin
                            if (b_q != 32'd0) begin
                                lo_d = quot_u;
                                hi_d = rem_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StBusy);
    end

    // State registers with synchronous reset taking priority over start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpNone;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // Outputs: HI/LO read port and stall request to the hazard unit
    always_comb begin
        rdata     = rd_hi ? hi_q : lo_q;
        busy      = busy_q;
        stall_req = busy_q || (start && is_muldiv(op_in));
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table of mul/div ops plus
// hand-written sequences for MT moves, divide-by-zero, ignored starts and reset.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hi;
    logic [31:0] rdata;
    logic        busy;
    logic        stall_req;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected HI/LO contents as tracked by the bench
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    typedef struct {
        string       name;
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        int          nbusy;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    mul_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .rd_hi    (rd_hi),
        .rdata    (rdata),
        .busy     (busy),
        .stall_req(stall_req)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        rd_hi = 1'b1;
        #1;
        hi = rdata;
        rd_hi = 1'b0;
        #1;
        lo = rdata;
    endtask

    // Issue one op, then count busy cycles while scrambling a/b; optionally
    // inject a second start at busy cycle inj_at.
    task automatic run_op(input string name, input md_op_e o, input logic [31:0] oa,
                          input logic [31:0] ob, input int inj_at, input md_op_e inj_op,
                          output int nbusy);
        logic stall_ok;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = oa;
        b     = ob;
        #1;
        check({name, " stall@start"}, 32'(stall_req), 32'(is_muldiv(o)));
        @(negedge clk);
        start    = 1'b0;
        op       = OpNone;
        rd_hi    = 1'b0;
        nbusy    = 0;
        stall_ok = 1'b1;
        while (busy && nbusy < 64) begin
            nbusy++;
            #1;
            if (!stall_req) stall_ok = 1'b0;
            if (nbusy == 1) check({name, " rdata during busy"}, rdata, lo_m);
            a = $urandom;
            b = $urandom;
            if (nbusy == inj_at) begin
                start = 1'b1;
                op    = inj_op;
            end else begin
                start = 1'b0;
                op    = OpNone;
            end
            @(negedge clk);
        end
        start = 1'b0;
        op    = OpNone;
        #1;
        check({name, " stall in busy"}, 32'(stall_ok), 32'd1);
        check({name, " stall after"}, 32'(stall_req), 32'd0);
    endtask

    initial begin
        int          nb;
        int          seen;
        logic [31:0] hi;
        logic [31:0] lo;

        vecs[0] = '{"mult -2*3",      OpMult,  32'hFFFF_FFFE, 32'd3,         5,
                    32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{"div -7/2",       OpDiv,   32'hFFFF_FFF9, 32'd2,         10,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{"divu -7/2",      OpDivu,  32'hFFFF_FFF9, 32'd2,         10,
                    32'h0000_0001, 32'h7FFF_FFFC};
        vecs[3] = '{"multu max*max",  OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
                    32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4] = '{"mult min*min",   OpMult,  32'h8000_0000, 32'h8000_0000, 5,
                    32'h4000_0000, 32'h0000_0000};
        vecs[5] = '{"div min/-1",     OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 10,
                    32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{"div 7/-2",       OpDiv,   32'd7,         32'hFFFF_FFFE, 10,
                    32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{"mult -1*5",      OpMult,  32'hFFFF_FFFF, 32'd5,         5,
                    32'hFFFF_FFFF, 32'hFFFF_FFFB};
        vecs[8] = '{"divu 100/7",     OpDivu,  32'd100,       32'd7,         10,
                    32'h0000_0002, 32'h0000_000E};

        reset = 1'b1;
        start = 1'b0;
        op    = OpNone;
        a     = '0;
        b     = '0;
        rd_hi = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset stall", 32'(stall_req), 32'd0);
        read_hl(hi, lo);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        // Table of mul/div ops
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 0, OpNone, nb);
            check({vecs[i].name, " busy cycles"}, 32'(nb), 32'(vecs[i].nbusy));
            read_hl(hi, lo);
            check({vecs[i].name, " hi"}, hi, vecs[i].hi);
            check({vecs[i].name, " lo"}, lo, vecs[i].lo);
            hi_m = vecs[i].hi;
            lo_m = vecs[i].lo;
        end

        // MTHI / MTLO never raise busy
        run_op("mthi", OpMthi, 32'h1234_5678, 32'd0, 0, OpNone, nb);
        check("mthi busy cycles", 32'(nb), 32'd0);
        hi_m = 32'h1234_5678;
        run_op("mtlo", OpMtlo, 32'h9ABC_DEF0, 32'd0, 0, OpNone, nb);
        check("mtlo busy cycles", 32'(nb), 32'd0);
        lo_m = 32'h9ABC_DEF0;
        read_hl(hi, lo);
        check("mt hi", hi, 32'h1234_5678);
        check("mt lo", lo, 32'h9ABC_DEF0);

        // NONE op does nothing
        run_op("none", OpNone, 32'hAAAA_AAAA, 32'h5555_5555, 0, OpNone, nb);
        check("none busy cycles", 32'(nb), 32'd0);
        read_hl(hi, lo);
        check("none hi", hi, hi_m);
        check("none lo", lo, lo_m);

        // Divide by zero keeps HI/LO; a MULT started mid-busy is ignored
        run_op("pre mthi", OpMthi, 32'h55, 32'd0, 0, OpNone, nb);
        hi_m = 32'h55;
        run_op("pre mtlo", OpMtlo, 32'h55, 32'd0, 0, OpNone, nb);
        lo_m = 32'h55;
        run_op("divu0", OpDivu, 32'h99, 32'd0, 2, OpMult, nb);
        check("divu0 busy cycles", 32'(nb), 32'd10);
        read_hl(hi, lo);
        check("divu0 hi", hi, 32'h55);
        check("divu0 lo", lo, 32'h55);
        repeat (8) @(negedge clk);
        #1;
        check("divu0 no late busy", 32'(busy), 32'd0);
        read_hl(hi, lo);
        check("divu0 lo later", lo, 32'h55);

        // Reset in the 3rd busy cycle of a MULT aborts it
        @(negedge clk);
        start = 1'b1;
        op    = OpMult;
        a     = 32'd3;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        op    = OpNone;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy next", 32'(busy), 32'd0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) seen++;
        end
        check("abort busy later", 32'(seen), 32'd0);
        read_hl(hi, lo);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        hi_m = '0;
        lo_m = '0;

        // Reset wins over a start at the same edge
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        op    = OpDiv;
        a     = 32'd9;
        b     = 32'd2;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        op    = OpNone;
        #1;
        check("reset prio busy", 32'(busy), 32'd0);
        repeat (12) @(negedge clk);
        read_hl(hi, lo);
        check("reset prio hi", hi, 32'd0);
        check("reset prio lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout, got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
